// File: rtl/video_src_sel_if.sv
// Signal bundle between the video source selector and its neighbours:
// source request, live RGB input stream and selected RGB output stream.
interface video_src_sel_if #(
    parameter int RGB_WIDTH = 24
) ();
    logic [1:0]           mode_req;
    logic [RGB_WIDTH-1:0] solid_color;
    logic [RGB_WIDTH-1:0] live_pix;
    logic                 live_valid;
    logic                 live_line;
    logic                 live_frame;
    logic [RGB_WIDTH-1:0] out_pix;
    logic                 out_valid;
    logic                 out_line;
    logic                 out_frame;
    logic [1:0]           mode_act;
    logic [15:0]          frame_cnt;

    modport master (
        output mode_req, solid_color, live_pix, live_valid, live_line, live_frame,
        input  out_pix, out_valid, out_line, out_frame, mode_act, frame_cnt
    );

    modport slave (
        input  mode_req, solid_color, live_pix, live_valid, live_line, live_frame,
        output out_pix, out_valid, out_line, out_frame, mode_act, frame_cnt
    );
endinterface

// File: rtl/video_src_sel.sv
// Frame-synchronous selector between the live ISP stream and generated test
// patterns. Define VIDEO_SRC_CHECKER_EN to turn mode 3 into an 8x8 checkerboard.
module video_src_sel #(
    parameter int LINE_LENGTH = 640,
    parameter int FRAME_LINES = 480,
    parameter int RGB_WIDTH   = 24,
    parameter int HBLANK      = 16,
    parameter int VBLANK      = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    video_src_sel_if.slave vif
);

    localparam int CW     = RGB_WIDTH / 3;
    localparam int PERIOD = HBLANK + LINE_LENGTH;
    localparam int VB_CYC = VBLANK * PERIOD;
    localparam int BAR_W  = LINE_LENGTH / 8;
    // x/y keep at least 4 bits so bit 3 exists for the checkerboard decode
    localparam int XW     = ($clog2(LINE_LENGTH) < 4) ? 4 : $clog2(LINE_LENGTH);
    localparam int YW     = ($clog2(FRAME_LINES) < 4) ? 4 : $clog2(FRAME_LINES);
    localparam int CNTW   = ($clog2(VB_CYC) < 1) ? 1 : $clog2(VB_CYC);
    localparam int BW     = ($clog2(BAR_W) < 1) ? 1 : $clog2(BAR_W);

    localparam logic [XW-1:0]   X_LAST   = XW'(LINE_LENGTH - 1);
    localparam logic [YW-1:0]   Y_LAST   = YW'(FRAME_LINES - 1);
    localparam logic [CNTW-1:0] HB_LAST  = CNTW'(HBLANK - 1);
    localparam logic [CNTW-1:0] VB_LAST  = CNTW'(VB_CYC - 1);
    localparam logic [BW-1:0]   BAR_LAST = BW'(BAR_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LIVE     = 3'd1,
        ST_GEN_HBLK = 3'd2,
        ST_GEN_LINE = 3'd3,
        ST_GEN_VBLK = 3'd4
    } state_t;

    state_t               state_r, state_s;
    logic [1:0]           mode_r, mode_s;
    logic [XW-1:0]        x_r, x_s;
    logic [YW-1:0]        y_r, y_s;
    logic [CNTW-1:0]      cnt_r, cnt_s;
    logic [BW-1:0]        bar_px_r, bar_px_s;
    logic [2:0]           bar_idx_r, bar_idx_s;
    logic                 live_frame_q_r;

    logic                 live_rise_s, live_fall_s, live_fwd_s, live_ok_s;
    logic [CW-1:0]        ramp_s;
    logic [RGB_WIDTH-1:0] pattern_s;

    logic [RGB_WIDTH-1:0] out_pix_r, out_pix_s;
    logic                 out_valid_r, out_valid_s;
    logic                 out_line_r, out_line_s;
    logic                 out_frame_r, out_frame_s;
    logic [1:0]           mode_act_r, mode_act_s;
    logic [15:0]          frame_cnt_r, frame_cnt_s;

    assign live_rise_s = vif.live_frame & ~live_frame_q_r;
    assign live_fall_s = ~vif.live_frame & live_frame_q_r;
    assign live_ok_s   = vif.live_valid & vif.live_line;
    assign ramp_s      = CW'(x_r);

    // Live-frame edge reference; resets high so a frame already running at
    // reset release is not mistaken for a fresh start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live_frame_q_r <= 1'b1;
        end else begin
            live_frame_q_r <= vif.live_frame;
        end
    end

    // FSM and pixel/line/blank counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            mode_r    <= 2'd0;
            x_r       <= {XW{1'b0}};
            y_r       <= {YW{1'b0}};
            cnt_r     <= {CNTW{1'b0}};
            bar_px_r  <= {BW{1'b0}};
            bar_idx_r <= 3'd0;
        end else begin
            state_r   <= state_s;
            mode_r    <= mode_s;
            x_r       <= x_s;
            y_r       <= y_s;
            cnt_r     <= cnt_s;
            bar_px_r  <= bar_px_s;
            bar_idx_r <= bar_idx_s;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        state_s   = state_r;
        mode_s    = mode_r;
        x_s       = x_r;
        y_s       = y_r;
        cnt_s     = cnt_r;
        bar_px_s  = bar_px_r;
        bar_idx_s = bar_idx_r;
        case (state_r)
            ST_IDLE: begin
                x_s       = {XW{1'b0}};
                y_s       = {YW{1'b0}};
                cnt_s     = {CNTW{1'b0}};
                bar_px_s  = {BW{1'b0}};
                bar_idx_s = 3'd0;
                if (vif.mode_req != 2'd0) begin
                    state_s = ST_GEN_HBLK;
                    mode_s  = vif.mode_req;
                end else if (live_rise_s) begin
                    state_s = ST_LIVE;
                    mode_s  = 2'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LIVE: begin
                if (live_fall_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_LIVE;
                end
            end
            ST_GEN_HBLK: begin
                if (cnt_r == HB_LAST) begin
                    cnt_s   = {CNTW{1'b0}};
                    state_s = ST_GEN_LINE;
                end else begin
                    cnt_s   = cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
                end
            end
            ST_GEN_LINE: begin
                if (x_r == X_LAST) begin
                    x_s       = {XW{1'b0}};
                    bar_px_s  = {BW{1'b0}};
                    bar_idx_s = 3'd0;
                    if (y_r == Y_LAST) begin
                        y_s     = {YW{1'b0}};
                        state_s = ST_GEN_VBLK;
                    end else begin
                        y_s     = y_r + {{(YW-1){1'b0}}, 1'b1};
                        state_s = ST_GEN_HBLK;
                    end
                end else begin
                    x_s = x_r + {{(XW-1){1'b0}}, 1'b1};
                    // bar index advances by counting, avoiding a divide by LINE_LENGTH/8
                    if (bar_px_r == BAR_LAST) begin
                        bar_px_s  = {BW{1'b0}};
                        bar_idx_s = bar_idx_r + 3'd1;
                    end else begin
                        bar_px_s  = bar_px_r + {{(BW-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_GEN_VBLK: begin
                if (cnt_r == VB_LAST) begin
                    cnt_s   = {CNTW{1'b0}};
                    state_s = ST_IDLE;
                end else begin
                    cnt_s   = cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Test-pattern colour for the current pixel position.
    always_comb begin
        pattern_s = {RGB_WIDTH{1'b0}};
        case (mode_r)
            // bar order white..black is exactly R=~b1, G=~b2, B=~b0 of the bar index
            2'd1: pattern_s = {{CW{~bar_idx_r[1]}}, {CW{~bar_idx_r[2]}}, {CW{~bar_idx_r[0]}}};
            2'd2: pattern_s = {ramp_s, ramp_s, ramp_s};
            2'd3: begin
`ifdef VIDEO_SRC_CHECKER_EN
                if (x_r[3] ^ y_r[3]) begin
                    pattern_s = ~vif.solid_color;
                end else begin
                    pattern_s = vif.solid_color;
                end
`else
                pattern_s = vif.solid_color;
`endif
            end
            default: pattern_s = {RGB_WIDTH{1'b0}};
        endcase
    end

    // Output decode; live data is forwarded on the very edge IDLE detects its start.
    always_comb begin
        live_fwd_s  = 1'b0;
        out_pix_s   = {RGB_WIDTH{1'b0}};
        out_valid_s = 1'b0;
        out_line_s  = 1'b0;
        out_frame_s = 1'b0;
        mode_act_s  = mode_act_r;
        case (state_r)
            ST_LIVE: live_fwd_s = 1'b1;
            ST_IDLE: live_fwd_s = (vif.mode_req == 2'd0) && live_rise_s;
            default: live_fwd_s = 1'b0;
        endcase
        if (live_fwd_s) begin
            out_valid_s = live_ok_s;
            out_line_s  = vif.live_line;
            out_frame_s = vif.live_frame;
            out_pix_s   = live_ok_s ? vif.live_pix : {RGB_WIDTH{1'b0}};
            mode_act_s  = 2'd0;
        end else if (state_r == ST_GEN_HBLK) begin
            out_frame_s = 1'b1;
            mode_act_s  = mode_r;
        end else if (state_r == ST_GEN_LINE) begin
            out_frame_s = 1'b1;
            out_line_s  = 1'b1;
            out_valid_s = 1'b1;
            out_pix_s   = pattern_s;
            mode_act_s  = mode_r;
        end else begin
            out_frame_s = 1'b0;
        end
        if (out_frame_r && !out_frame_s) begin
            frame_cnt_s = frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_s = frame_cnt_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_pix_r   <= {RGB_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            out_line_r  <= 1'b0;
            out_frame_r <= 1'b0;
            mode_act_r  <= 2'd0;
            frame_cnt_r <= 16'd0;
        end else begin
            out_pix_r   <= out_pix_s;
            out_valid_r <= out_valid_s;
            out_line_r  <= out_line_s;
            out_frame_r <= out_frame_s;
            mode_act_r  <= mode_act_s;
            frame_cnt_r <= frame_cnt_s;
        end
    end

    assign vif.out_pix   = out_pix_r;
    assign vif.out_valid = out_valid_r;
    assign vif.out_line  = out_line_r;
    assign vif.out_frame = out_frame_r;
    assign vif.mode_act  = mode_act_r;
    assign vif.frame_cnt = frame_cnt_r;

endmodule
